fir_tdm_sched: RTL and testbench

- Time-division scheduler for the AM demodulator's I/Q low-pass filtering. One signed multiply-accumulate is shared between the I and Q channels.
- On each sample strobe (next_lrclk_fall) it captures one I and one Q sample into per-channel circular delay lines, then sequences the MAC through all taps of I and then all taps of Q.
- It rounds and saturates both results and presents them together with a one-cycle valid pulse.
- It replaces the two dedicated filter instances in the demodulator path.

---
 rtl/fir_tdm_sched.sv | 155 +++++++++++++++
 tb/tb_fir_tdm_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_sched.sv
// Shared-MAC I/Q low-pass FIR: one signed multiply-accumulate walks all taps of I,
// then all taps of Q, per sample strobe; results are rounded, saturated and pulsed out together.
module fir_tdm_sched #(
  parameter int L      = 24,
  parameter int M      = 16,
  parameter int DELAYS = 40
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      next_lrclk_fall,
  input  logic [L-1:0]              i,
  input  logic [L-1:0]              q,
  input  logic [DELAYS:0][M-1:0]    b,
  output logic [L-1:0]              i_out,
  output logic [L-1:0]              q_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);
  localparam int N    = DELAYS + 1;
  localparam int PTRW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = L + M;
  localparam int AW   = L + M + $clog2(N);

  localparam logic [PTRW-1:0]   LAST = PTRW'(DELAYS);
  localparam logic signed [AW-1:0] MAXV = {{(AW-L+1){1'b0}}, {(L-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-L+1){1'b1}}, {(L-1){1'b0}}};
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (M-2);

  typedef enum logic [1:0] {IDLE, MAC_I, MAC_Q, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]        k_q, k_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [AW-1:0]   i_hold_q, i_hold_d;
  logic [L-1:0]           i_out_q, i_out_d;
  logic [L-1:0]           q_out_q, q_out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   accept;
  logic [L-1:0]           xi_q [N];
  logic [L-1:0]           xq_q [N];

  logic [PTRW:0]          wrap_idx;
  logic [PTRW-1:0]        rd_idx;
  logic [L-1:0]           samp;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_ext;

  // Circular read index: newest sample sits at wr_ptr, tap k reaches k frames back.
  always_comb begin
    wrap_idx = {1'b0, wr_ptr_q} + (PTRW+1)'(N) - {1'b0, k_q};
    rd_idx   = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : wrap_idx[PTRW-1:0];
    samp     = (state_q == MAC_Q) ? xq_q[rd_idx] : xi_q[rd_idx];
    prod     = $signed(b[k_q]) * $signed(samp);
    prod_ext = AW'(prod);
  end

  function automatic logic [L-1:0] rnd_sat(input logic signed [AW-1:0] x);
    logic signed [AW-1:0] r;
    r = (x + HALF) >>> (M-1);
    if (r > MAXV)      return MAXV[L-1:0];
    else if (r < MINV) return MINV[L-1:0];
    else               return r[L-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    i_hold_d    = i_hold_q;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (next_lrclk_fall && (state_q != IDLE));
    accept      = 1'b0;
    case (state_q)
      IDLE: if (next_lrclk_fall) begin
        accept  = 1'b1;
        k_d     = '0;
        state_d = MAC_I;
      end
      MAC_I: begin
        acc_d = (k_q == '0) ? prod_ext : acc_q + prod_ext;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = MAC_Q;
        end else k_d = k_q + PTRW'(1);
      end
      MAC_Q: begin
        if (k_q == '0) begin
          i_hold_d = acc_q;
          acc_d    = prod_ext;
        end else acc_d = acc_q + prod_ext;
        if (k_q == LAST) begin
          k_d     = '0;
          state_d = DONE;
        end else k_d = k_q + PTRW'(1);
      end
      DONE: begin
        i_out_d     = rnd_sat(i_hold_q);
        q_out_d     = rnd_sat(acc_q);
        out_valid_d = 1'b1;
        wr_ptr_d    = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTRW'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      i_hold_q    <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      i_hold_q    <= i_hold_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int n = 0; n < N; n++) begin
        xi_q[n] <= '0;
        xq_q[n] <= '0;
      end
    end else if (accept) begin
      xi_q[wr_ptr_q] <= i;
      xq_q[wr_ptr_q] <= q;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_tdm_sched.sv
// Scoreboard bench for fir_tdm_sched: a direct-form FIR reference predicts each frame,
// expectations are queued at the strobe and popped when out_valid fires.
module tb_fir_tdm_sched;
  localparam int L = 24, M = 16, DELAYS = 40, N = DELAYS + 1, LAT = 2*N + 1;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   strobe = 1'b0;
  logic [L-1:0]           iv = '0, qv = '0;
  logic [DELAYS:0][M-1:0] bv = '0;
  logic [L-1:0]           i_out, q_out;
  logic                   out_valid, busy, overrun;

  fir_tdm_sched #(.L(L), .M(M), .DELAYS(DELAYS)) dut (
    .clk(clk), .reset_n(reset_n), .next_lrclk_fall(strobe), .i(iv), .q(qv), .b(bv),
    .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference history, index 0 = newest sample
  int hi [N];
  int hq [N];
  logic [L-1:0] exp_iq[$], exp_qq[$];
  int           exp_cq[$];
  logic [L-1:0] last_i = '0, last_q = '0;

  function automatic logic [L-1:0] fir_ref(input bit ch_q);
    longint s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(bv[k])) * longint'(ch_q ? hq[k] : hi[k]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 64'sd8388607) s = 64'sd8388607;
    else if (s < -64'sd8388608) s = -64'sd8388608;
    return s[L-1:0];
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_iq.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        chk("i_out", i_out, exp_iq.pop_front());
        chk("q_out", q_out, exp_qq.pop_front());
        chk("latency", cyc, exp_cq.pop_front());
      end
      last_i = i_out;
      last_q = q_out;
    end
  end

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin hi[k] = 0; hq[k] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  // One-cycle strobe; when accept is set the model takes the sample and queues its prediction.
  task automatic strobe_in(input logic [L-1:0] si, input logic [L-1:0] sq, input bit accept,
                           output int c0);
    @(negedge clk);
    strobe = 1'b1; iv = si; qv = sq;
    @(negedge clk);
    strobe = 1'b0;
    c0 = cyc;
    if (accept) begin
      for (int k = N-1; k > 0; k--) begin hi[k] = hi[k-1]; hq[k] = hq[k-1]; end
      hi[0] = $signed(si);
      hq[0] = $signed(sq);
      exp_iq.push_back(fir_ref(1'b0));
      exp_qq.push_back(fir_ref(1'b1));
      exp_cq.push_back(c0 + LAT);
    end
  endtask

  task automatic frame(input logic [L-1:0] si, input logic [L-1:0] sq, input int gap);
    int c0;
    strobe_in(si, sq, 1'b1, c0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int c0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_i_out", i_out, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;

    // Impulse gain and exact latency / busy window
    bv = '0; bv[0] = 16'd16384;
    strobe_in(24'h100000, 24'hF00000, 1'b1, c0);
    chk("imp_busy_early", busy, 1);
    repeat (LAT-1) @(negedge clk);
    chk("imp_busy_late", busy, 1);
    chk("imp_no_early_valid", out_valid, 0);
    @(negedge clk);
    chk("imp_valid", out_valid, 1);
    @(negedge clk);
    chk("imp_busy_off", busy, 0);
    chk("imp_valid_pulse", out_valid, 0);
    chk("imp_i", last_i, 24'h080000);
    chk("imp_q", last_q, 24'hF80000);

    // Delay and pointer wrap
    do_reset();
    bv = '0; bv[5] = 16'd16384;
    for (int f = 0; f < 60; f++) begin
      frame((f == 38) ? 24'h200000 : 24'h0, 24'h0, 199);
      chk("dly_i", last_i, (f == 43) ? 24'h100000 : 24'h0);
      chk("dly_q", last_q, 24'h0);
    end

    // Saturation both directions
    do_reset();
    for (int k = 0; k < N; k++) bv[k] = 16'd32767;
    for (int f = 0; f < 41; f++) frame(24'h7FFFFF, 24'h0, 89);
    chk("sat_pos", last_i, 24'h7FFFFF);
    for (int f = 0; f < 41; f++) frame(24'h800000, 24'h0, 89);
    chk("sat_neg", last_i, 24'h800000);

    // Rounding half up
    do_reset();
    bv = '0; bv[0] = 16'd1;
    frame(24'h004000, 24'h0, 89);
    chk("rnd_up", last_i, 24'h000001);
    frame(24'h003FFF, 24'h0, 89);
    chk("rnd_down", last_i, 24'h000000);

    // Overrun: second strobe dropped, flag sticky, history unaffected
    do_reset();
    bv = '0; bv[0] = 16'd16384; bv[1] = 16'd8192;
    strobe_in(24'h100000, 24'h0, 1'b1, c0);
    repeat (9) @(negedge clk);
    strobe_in(24'h300000, 24'h0, 1'b0, c0);
    repeat (89) @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_first_i", last_i, 24'h080000);
    frame(24'h0, 24'h0, 89);
    chk("ovr_hist_i", last_i, 24'h040000);
    chk("ovr_sticky", overrun, 1);

    // Reset mid-frame abandons the frame and clears history
    strobe_in(24'h123456, 24'h654321, 1'b0, c0);
    repeat (18) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    @(negedge clk);
    chk("mrst_i_out", i_out, 0);
    chk("mrst_q_out", q_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_overrun", overrun, 0);
    repeat (100) @(negedge clk);
    bv = '0; bv[0] = 16'd16384; bv[1] = 16'd16384;
    frame(24'h100000, 24'h0, 89);
    chk("mrst_clean_i", last_i, 24'h080000);
    chk("mrst_clean_q", last_q, 24'h0);

    repeat (10) @(negedge clk);
    chk("pending", exp_iq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
